bcd_display_mux: RTL and testbench

Multiplexed seven-segment display driver that consumes packed BCD digits from the BCD counter chain and scans them onto a common-anode display. It sits directly downstream of the cascaded BCD counters. A `load` strobe atomically snapshots all digits so the display never shows a half-updated count. A programmable prescaler sets the per-digit dwell time, and one dead cycle at each digit switch suppresses ghosting.

---
 rtl/bcd_display_pkg.sv | 21 ++
 rtl/bcd_display_mux_if.sv | 26 ++
 rtl/bcd_to_7seg.sv | 27 ++
 rtl/bcd_display_mux.sv | 114 +++++++++++
 tb/tb_bcd_display_mux.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - segment type and glyph constants for the BCD display mux
// Glyphs are active low, bit order {g,f,e,d,c,b,a}.
package bcd_display_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'b1111111;
   localparam seg_t SEG_DASH  = 7'b0111111;

   localparam seg_t SEG_0 = 7'b1000000;
   localparam seg_t SEG_1 = 7'b1111001;
   localparam seg_t SEG_2 = 7'b0100100;
   localparam seg_t SEG_3 = 7'b0110000;
   localparam seg_t SEG_4 = 7'b0011001;
   localparam seg_t SEG_5 = 7'b0010010;
   localparam seg_t SEG_6 = 7'b0000010;
   localparam seg_t SEG_7 = 7'b1111000;
   localparam seg_t SEG_8 = 7'b0000000;
   localparam seg_t SEG_9 = 7'b0010000;

endpackage

// File: rtl/bcd_display_mux_if.sv
// rtl/bcd_display_mux_if.sv - digit source / display pins bundle for bcd_display_mux
// master drives the snapshot inputs; slave is the display driver.
interface bcd_display_mux_if #(
   parameter int DIGITS = 4
);
   import bcd_display_pkg::*;

   logic [4*DIGITS-1:0] bcd_in;
   logic [DIGITS-1:0]   dp_in;
   logic                load;
   logic [DIGITS-1:0]   an_n;
   seg_t                seg_n;
   logic                dp_n;
   logic                frame_done;

   modport master (
      output bcd_in, dp_in, load,
      input  an_n, seg_n, dp_n, frame_done
   );

   modport slave (
      input  bcd_in, dp_in, load,
      output an_n, seg_n, dp_n, frame_done
   );

endinterface

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD to active-low seven-segment decoder
// Codes 10-15 are not valid BCD and render as a dash.
module bcd_to_7seg
   import bcd_display_pkg::*;
(
   input  logic [3:0] bcd,
   output seg_t       seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - multiplexed common-anode BCD display scanner with load snapshot
// Define BCD_DISPLAY_LZB_EN to blank leading zeros (digit 0 is always shown).
module bcd_display_mux
   import bcd_display_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   bcd_display_mux_if.slave      disp
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] shd_bcd_q, shd_bcd_d;
   logic [DIGITS-1:0]   shd_dp_q, shd_dp_d;
   logic [DIGITS-1:0]   an_n_q, an_n_d;
   seg_t                seg_n_q, seg_n_d;
   logic                dp_n_q, dp_n_d;
   logic                frame_done_q, frame_done_d;

   logic       dead;
   logic [3:0] cur_bcd;
   seg_t       dec_seg;
   logic       blank_digit;

   assign dead    = (div_cnt_q == DIV_LAST);
   assign cur_bcd = shd_bcd_q[{idx_q, 2'b00} +: 4];

   bcd_to_7seg u_dec (
      .bcd (cur_bcd),
      .seg (dec_seg)
   );

`ifdef BCD_DISPLAY_LZB_EN
   // lz[k] is set when digit k and every more-significant digit are zero.
   logic [DIGITS-1:0] lz;

   always_comb begin
      lz = '0;
      lz[DIGITS-1] = (shd_bcd_q[4*DIGITS-1 -: 4] == 4'd0);
      for (int k = DIGITS - 2; k >= 0; k--) begin
         lz[k] = lz[k+1] && (shd_bcd_q[4*k +: 4] == 4'd0);
      end
   end

   assign blank_digit = (idx_q != '0) && lz[idx_q];
`else
   assign blank_digit = 1'b0;
`endif

   always_comb begin
      div_cnt_d    = div_cnt_q + 1'b1;
      idx_d        = idx_q;
      shd_bcd_d    = shd_bcd_q;
      shd_dp_d     = shd_dp_q;
      an_n_d       = '1;
      seg_n_d      = SEG_BLANK;
      dp_n_d       = 1'b1;
      frame_done_d = 1'b0;

      if (disp.load) begin
         shd_bcd_d = disp.bcd_in;
         shd_dp_d  = disp.dp_in;
      end

      if (dead) begin
         div_cnt_d    = '0;
         idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         frame_done_d = (idx_q == IDX_LAST);
      end else begin
         // Outputs come from the pre-edge shadow, so a load never tears a cycle.
         an_n_d  = ~(AN_ONE << idx_q);
         seg_n_d = blank_digit ? SEG_BLANK : dec_seg;
         dp_n_d  = ~shd_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_cnt_q    <= '0;
         idx_q        <= '0;
         shd_bcd_q    <= '0;
         shd_dp_q     <= '0;
         an_n_q       <= '1;
         seg_n_q      <= SEG_BLANK;
         dp_n_q       <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         idx_q        <= idx_d;
         shd_bcd_q    <= shd_bcd_d;
         shd_dp_q     <= shd_dp_d;
         an_n_q       <= an_n_d;
         seg_n_q      <= seg_n_d;
         dp_n_q       <= dp_n_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign disp.an_n       = an_n_q;
   assign disp.seg_n      = seg_n_q;
   assign disp.dp_n       = dp_n_q;
   assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// tb/tb_bcd_display_mux.sv - directed self-checking bench for bcd_display_mux (DIGITS=4, REFRESH_DIV=4)
module tb_bcd_display_mux;

   logic clk;
   logic reset_n;

   bcd_display_mux_if #(.DIGITS(4)) disp ();

   bcd_display_mux #(
      .DIGITS      (4),
      .REFRESH_DIV (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .disp    (disp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Expected position in the scan and the expected glyph per digit.
   int         exp_div;
   int         exp_idx;
   logic [6:0] exp_seg [4];
   logic [3:0] exp_dp;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic set_segs(input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0);
      exp_seg[3] = s3;
      exp_seg[2] = s2;
      exp_seg[1] = s1;
      exp_seg[0] = s0;
   endtask

   task automatic tick(input string tag);
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic       e_fd;
      @(posedge clk);
      #1;
      if (exp_div == 3) begin
         e_an  = 4'b1111;
         e_seg = 7'b1111111;
         e_dp  = 1'b1;
      end else begin
         e_an  = ~(4'b0001 << exp_idx);
         e_seg = exp_seg[exp_idx];
         e_dp  = ~exp_dp[exp_idx];
      end
      e_fd = (exp_div == 3) && (exp_idx == 3);
      check({tag, "_an"},  {28'd0, disp.an_n},       {28'd0, e_an});
      check({tag, "_seg"}, {25'd0, disp.seg_n},      {25'd0, e_seg});
      check({tag, "_dp"},  {31'd0, disp.dp_n},       {31'd0, e_dp});
      check({tag, "_fd"},  {31'd0, disp.frame_done}, {31'd0, e_fd});
      if (exp_div == 3) begin
         exp_div = 0;
         exp_idx = (exp_idx == 3) ? 0 : exp_idx + 1;
      end else begin
         exp_div++;
      end
   endtask

   task automatic reset_checks(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_an"},  {28'd0, disp.an_n},       32'h0000000f);
      check({tag, "_seg"}, {25'd0, disp.seg_n},      32'h0000007f);
      check({tag, "_dp"},  {31'd0, disp.dp_n},       32'h00000001);
      check({tag, "_fd"},  {31'd0, disp.frame_done}, 32'h00000000);
   endtask

   initial begin
      reset_n     = 1'b0;
      disp.bcd_in = 16'hFFFF;
      disp.dp_in  = 4'hF;
      disp.load   = 1'b1;

      // Reset held three cycles with load asserted: reset must win.
      for (int i = 0; i < 3; i++) reset_checks("rst");

      reset_n   = 1'b1;
      disp.load = 1'b0;
      exp_div   = 0;
      exp_idx   = 0;
      exp_dp    = 4'b0000;
      set_segs(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
      tick("post_rst");

      // Scan order with 1234; shadow takes effect one edge after the load.
      disp.bcd_in = 16'h1234;
      disp.dp_in  = 4'b0000;
      disp.load   = 1'b1;
      tick("load1234");
      disp.load = 1'b0;
      set_segs(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);
      for (int i = 0; i < 34; i++) tick("scan1234");

      // Inputs churn without load: display must not move.
      for (int i = 0; i < 16; i++) begin
         disp.bcd_in = 16'($urandom);
         disp.dp_in  = 4'($urandom);
         tick("hold");
      end

      disp.bcd_in = 16'h9876;
      disp.dp_in  = 4'b0000;
      disp.load   = 1'b1;
      tick("load9876");
      disp.load = 1'b0;
      set_segs(7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010);
      for (int i = 0; i < 18; i++) tick("scan9876");

      // Invalid BCD, loaded on a dead cycle (digit switch).
      for (int i = 0; i < 4 && exp_div != 3; i++) tick("align");
      disp.bcd_in = 16'hF0A5;
      disp.dp_in  = 4'b0100;
      disp.load   = 1'b1;
      tick("loadF0A5");
      disp.load = 1'b0;
      exp_dp    = 4'b0100;
      set_segs(7'b0111111, 7'b1000000, 7'b0111111, 7'b0010010);
      for (int i = 0; i < 17; i++) tick("invalid");

      // Leading zeros.
      disp.bcd_in = 16'h0007;
      disp.dp_in  = 4'b0000;
      disp.load   = 1'b1;
      tick("load0007");
      disp.load = 1'b0;
      exp_dp    = 4'b0000;
`ifdef BCD_DISPLAY_LZB_EN
      set_segs(7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000);
`else
      set_segs(7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000);
`endif
      for (int i = 0; i < 16; i++) tick("lzb7");

      disp.bcd_in = 16'h0000;
      disp.dp_in  = 4'b0010;
      disp.load   = 1'b1;
      tick("load0000");
      disp.load = 1'b0;
      exp_dp    = 4'b0010;
`ifdef BCD_DISPLAY_LZB_EN
      set_segs(7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000);
`else
      set_segs(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
`endif
      for (int i = 0; i < 16; i++) tick("lzb0");

      // Mid-frame reset while digit 2 is being driven.
      disp.bcd_in = 16'h1234;
      disp.dp_in  = 4'b1111;
      disp.load   = 1'b1;
      tick("load_pre_rst");
      disp.load = 1'b0;
      exp_dp    = 4'b1111;
      set_segs(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);
      for (int i = 0; i < 16 && !(exp_idx == 2 && exp_div == 1); i++) tick("seek");
      check("seek_idx2", exp_idx, 2);
      reset_n = 1'b0;
      reset_checks("mid_rst");
      reset_n = 1'b1;
      exp_div = 0;
      exp_idx = 0;
      exp_dp  = 4'b0000;
      set_segs(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
      for (int i = 0; i < 8; i++) tick("resume");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
